// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and defaults for the fifo write arbiter.
//   arb_state_t : ARB (free round-robin arbitration) / LOCK (burst held by owner)
//   DATA_W_DEF  : default word width, equal to the fifo data width
// Optional feature macro used by the arbiter: FIFO_ARB_BURST_EN
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int DATA_W_DEF = 8;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer request side and the fifo write side of the arbiter.
//   req / req_data / req_last : producer requests, packed words, end-of-packet
//   gnt                       : one-hot accept back to the producers
//   fifo_full                 : fifo backpressure
//   fifo_wr_en / fifo_data_in : fifo write port
//   owner / locked            : last granted producer, burst lock active
//   dbg_state / dbg_burst_cnt : internal FSM state and burst counter
// Modports: master = arbiter side, slave = producers + fifo side.
//
// Handshake: a producer raises req[i] with its word on req_data and holds
// both until gnt[i]; a cycle with gnt[i]=1 (which implies fifo_wr_en=1 and
// fifo_full=0) is the single transfer, no extra ready/valid phase exists.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 16
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        gnt;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic [IW-1:0]             owner;
    logic                      locked;
    arb_state_t                dbg_state;
    logic [CW-1:0]             dbg_burst_cnt;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output gnt, fifo_wr_en, fifo_data_in, owner, locked, dbg_state, dbg_burst_cnt
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  gnt, fifo_wr_en, fifo_data_in, owner, locked, dbg_state, dbg_burst_cnt
    );

endinterface : fifo_wr_arbiter_if

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating priority encoder. Searches (req & mask) starting at
// (rr_ptr+1) mod N and returns the first set position.
//   req    : request vector
//   mask   : eligibility mask (all ones when free, one-hot owner when locked)
//   rr_ptr : index of the last winner
//   gnt    : one-hot winner
//   idx    : binary index of the winner (0 when none)
//   any    : a winner exists
// ---------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] eligible;
    int           pos;

    assign eligible = req & mask;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        // Offsets 1..N visit every position once, the previous winner last.
        for (int k = 1; k <= N; k++) begin
            pos = (int'(rr_ptr) + k) % N;
            if (!any && eligible[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one synchronous fifo write port among NUM_REQ
// producers. Grant is combinational (zero latency) and suppressed whenever
// fifo_full or rst is high.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fifo_wr_arbiter_if.master (requests, grants, fifo write port,
//              owner, locked, debug state)
// Optional feature: FIFO_ARB_BURST_EN enables the ARB/LOCK burst FSM; the
// owner keeps the port until req_last, MAX_BURST words, or it drops req.
// Without it the arbiter is plain per-word round robin and locked is 0.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     owner_q;

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  data_mux;

    // While locked only the owner is eligible; a dropped owner req therefore
    // yields no grant in that cycle.
    always_comb begin
        mask = '1;
        if (state_q == LOCK) begin
            mask          = '0;
            mask[owner_q] = 1'b1;
        end
    end

    // Backpressure and reset kill the grant before the encoder sees it.
    assign pick_req = (rst || bus.fifo_full) ? '0 : bus.req;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req    (pick_req),
        .mask   (mask),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Data is held at zero when nothing is written.
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                data_mux = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (pick_any && !bus.req_last[pick_idx]) begin
                    state_d = LOCK;
                    cnt_d   = CW'(1);
                end
            end
            LOCK: begin
                if (!bus.req[owner_q]) begin
                    // Owner abandoned the packet: release without a grant.
                    state_d = ARB;
                end else if (pick_any) begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.req_last[owner_q] || (cnt_d == CW'(MAX_BURST))) begin
                        state_d = ARB;
                    end
                end
                // fifo_full with owner still requesting: stay, count holds.
            end
            default: state_d = ARB;
        endcase
    end

    assign bus.locked = (state_q == LOCK);
`else
    assign state_d    = ARB;
    assign cnt_d      = '0;
    assign bus.locked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB;
            cnt_q    <= '0;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            owner_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Pointing at the winner makes the next search start just past it.
            if (pick_any) begin
                rr_ptr_q <= pick_idx;
                owner_q  <= pick_idx;
            end
        end
    end

    assign bus.gnt           = pick_gnt;
    assign bus.fifo_wr_en    = pick_any;
    assign bus.fifo_data_in  = data_mux;
    assign bus.owner         = owner_q;
    assign bus.dbg_state     = state_q;
    assign bus.dbg_burst_cnt = cnt_q;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter. The driver issues one cycle of stimulus
// per step together with the hand-derived expected grant; expected writes go
// into exp_q and a monitor pops/compares on every fifo write.
// Burst scenarios are compiled in only with FIFO_ARB_BURST_EN.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;
  int seq    = 0;

  logic [NR+DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [NR+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got gnt=%b data=%h expected no write at %0t",
                   bus.gnt, bus.fifo_data_in, $time);
        end else begin
          e = exp_q.pop_front();
          check("write_gnt", 32'(bus.gnt), 32'(e[DW +: NR]));
          check("write_data", 32'(bus.fifo_data_in), 32'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: apply inputs just after posedge, check at negedge.
  task automatic step_d(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic f,
                        input logic [NR-1:0] eg, input logic lk, input logic [NR*DW-1:0] d);
    logic [DW-1:0] ed;
    bus.req       = r;
    bus.req_last  = l;
    bus.fifo_full = f;
    bus.req_data  = d;
    ed = '0;
    if (eg != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (eg[i]) ed = d[i*DW +: DW];
      end
      exp_q.push_back({eg, ed});
    end
    @(negedge clk);
    check("locked", 32'(bus.locked), 32'(lk));
    if (eg == '0) begin
      check("idle_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      check("idle_data", 32'(bus.fifo_data_in), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic f,
                      input logic [NR-1:0] eg, input logic lk);
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = 8'(seq * 5 + i * 64);
    seq++;
    step_d(r, l, f, eg, lk, d);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    bus.req_data  = 32'h44332211;

    // Test 1: reset blocks grants, then rotation 0,1,2,3,0
    @(negedge clk);
    check("rst_gnt_0", 32'(bus.gnt), 32'd0);
    check("rst_wr_en_0", 32'(bus.fifo_wr_en), 32'd0);
    @(negedge clk);
    check("rst_gnt_1", 32'(bus.gnt), 32'd0);
    check("rst_wr_en_1", 32'(bus.fifo_wr_en), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_data", 32'(bus.fifo_data_in), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0);
    step(4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0);

    // Test 2: two requesters alternate
    step(4'b1010, 4'b1010, 1'b0, 4'b0010, 1'b0);
    step(4'b1010, 4'b1010, 1'b0, 4'b1000, 1'b0);
    step(4'b1010, 4'b1010, 1'b0, 4'b0010, 1'b0);
    step(4'b1010, 4'b1010, 1'b0, 4'b1000, 1'b0);
    check("owner_after_t2", 32'(bus.owner), 32'd3);

    // Test 3: fifo_full stalls, then immediate grant with A5
    step_d(4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0, 32'h00A50000);
    step_d(4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0, 32'h00A50000);
    step_d(4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0, 32'h00A50000);
    step_d(4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 32'h00A50000);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

`ifdef FIFO_ARB_BURST_EN
    // Test 4: 5-word packet from req0 while req1 waits
    step(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0);
    step(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1);
    step(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1);
    step(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1);
    step(4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1);
    step(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0);
    check("owner_after_t4", 32'(bus.owner), 32'd1);

    // Test 5: forced release after MAX_BURST words, req2 goes next
    step(4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b0);
    for (int w = 1; w <= MB; w++) begin
      step(4'b0101, 4'b0000, 1'b0, 4'b0001, (w > 1));
    end
    step(4'b0101, 4'b0100, 1'b0, 4'b0100, 1'b0);
    step(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1);
    step(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1);

    // Test 6: full while locked, then owner aborts
    step(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0);
    step(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1);
    step(4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1);
    step(4'b0101, 4'b0101, 1'b0, 4'b0100, 1'b0);
    step(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
`endif

    // Drain: every expected write must have been seen
    @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
